// File: rtl/uart_rx_if.sv
// uart_rx_if: serial-line and received-byte signals between a line driver (master) and uart_rx (slave)
interface uart_rx_if;
  logic       rx;
  logic       parity_en;
  logic       even_parity;
  logic [7:0] data_out;
  logic       rx_valid;
  logic       rx_busy;
  logic       parity_err;
  logic       frame_err;
  modport master(output rx, parity_en, even_parity,
                 input  data_out, rx_valid, rx_busy, parity_err, frame_err);
  modport slave (input  rx, parity_en, even_parity,
                 output data_out, rx_valid, rx_busy, parity_err, frame_err);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: UART receiver, 1 start, 8 data LSB first, optional even/odd parity, 1 stop bit
// Ports: clk, rst (sync, active-high); bus (uart_rx_if.slave): rx line in, parity_en/even_parity
// config in, data_out/rx_valid/rx_busy/parity_err/frame_err out.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around each bit midpoint.
module uart_rx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int SYNC_STAGES  = 2
) (
  input logic     clk,
  input logic     rst,
  uart_rx_if.slave bus
);
  localparam int CW = $clog2(CLKS_PER_BIT);
`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif
  // the majority vote decides one cycle after the midpoint, so only the start wait stretches
  localparam logic [CW-1:0] LAST_START = CW'(CLKS_PER_BIT / 2 - 1 + MAJ);
  localparam logic [CW-1:0] LAST_BIT   = CW'(CLKS_PER_BIT - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic [CW-1:0]          r_cnt;
  logic [2:0]             r_bits;
  logic [7:0]             r_shift;
  logic                   r_par_en;
  logic                   r_even;
  logic                   r_perr;
  logic [7:0]             r_data;
  logic                   r_valid;
  logic                   r_busy;
  logic                   r_parity_err;
  logic                   r_frame_err;
  logic                   w_rxs;
  logic                   w_bit;
  logic                   w_last;
  assign w_rxs  = r_sync[SYNC_STAGES-1];
  assign w_last = r_cnt == ((r_state == START) ? LAST_START : LAST_BIT);
`ifdef UART_RX_MAJORITY_EN
  logic [1:0] r_hist;
  always_ff @(posedge clk)
    if (rst) r_hist <= 2'b11;
    else     r_hist <= {r_hist[0], w_rxs};
  assign w_bit = (r_hist[1] & r_hist[0]) | (r_hist[1] & w_rxs) | (r_hist[0] & w_rxs);
`else
  assign w_bit = w_rxs;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync       <= '1;
      r_prev       <= 1'b1;
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_bits       <= '0;
      r_shift      <= '0;
      r_par_en     <= 1'b0;
      r_even       <= 1'b0;
      r_perr       <= 1'b0;
      r_data       <= '0;
      r_valid      <= 1'b0;
      r_busy       <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], bus.rx};
      r_prev  <= w_rxs;
      r_valid <= 1'b0;
      r_cnt   <= (r_state == IDLE || w_last) ? '0 : r_cnt + CW'(1);
      case (r_state)
        IDLE:
          if (r_prev && !w_rxs) begin
            r_state  <= START;
            r_busy   <= 1'b1;
            r_par_en <= bus.parity_en;
            r_even   <= bus.even_parity;
          end
        START:
          if (w_last) begin
            r_state <= w_bit ? IDLE : DATA;
            r_busy  <= !w_bit;
            r_bits  <= '0;
          end
        DATA:
          if (w_last) begin
            r_shift <= {w_bit, r_shift[7:1]};
            r_bits  <= r_bits + 3'd1;
            if (r_bits == 3'd7) r_state <= r_par_en ? PARITY : STOP;
          end
        PARITY:
          if (w_last) begin
            r_perr  <= ^r_shift ^ w_bit ^ !r_even;
            r_state <= STOP;
          end
        STOP:
          if (w_last) begin
            r_state      <= IDLE;
            r_busy       <= 1'b0;
            r_valid      <= 1'b1;
            r_data       <= r_shift;
            r_frame_err  <= !w_bit;
            r_parity_err <= r_par_en & r_perr;
          end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.data_out   = r_data;
  assign bus.rx_valid   = r_valid;
  assign bus.rx_busy    = r_busy;
  assign bus.parity_err = r_parity_err;
  assign bus.frame_err  = r_frame_err;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx, directed and random frames against a frame-level model
module tb_uart_rx;
  localparam int CPB = 16;
  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  logic [7:0] last_d = 8'h00;
  bit   after = 1'b0;
  uart_rx_if bus();
  uart_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask
  // Drives one frame on the pin; the expected result comes from the frame rules, not the DUT.
  task automatic send(input logic [7:0] d, input logic pen, input logic ev, input logic pb,
                      input logic sb, input int glitch = -1, input int abort_at = -1);
    logic [10:0] bits;
    int n;
    bits = pen ? {sb, pb, d, 1'b0} : {1'b1, sb, d, 1'b0};
    n = pen ? 11 : 10;
    bus.parity_en = pen;
    bus.even_parity = ev;
    if (abort_at < 0) begin
      exp_q.push_back({d, pen && ((^d ^ pb) != !ev), !sb});
      last_d = d;
    end
    for (int i = 0; i < n; i++)
      for (int c = 0; c < CPB; c++) begin
        if (i == abort_at && c == 4) begin
          rst = 1'b1;
          bus.rx = 1'b1;
          tick();
          rst = 1'b0;
          last_d = 8'h00;
          return;
        end
        bus.rx = (i == glitch && c == CPB / 2) ? !bits[i] : bits[i];
        tick();
      end
  endtask
  task automatic idle(input int n);
    bus.rx = 1'b1;
    tick(n);
  endtask
  always @(negedge clk) begin
    if (after) begin
      checks++;
      if (bus.rx_valid || bus.rx_busy) begin
        errors++;
        $display("FAIL after_pulse valid=%0b busy=%0b required 0 0", bus.rx_valid, bus.rx_busy);
      end
      after = 1'b0;
    end
    if (!rst && bus.rx_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid data=%0h", bus.data_out);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if ({bus.data_out, bus.parity_err, bus.frame_err} !== e) begin
          errors++;
          $display("FAIL frame data=%0h pe=%0b fe=%0b required data=%0h pe=%0b fe=%0b",
                   bus.data_out, bus.parity_err, bus.frame_err, e.d, e.pe, e.fe);
        end
      end
      after = 1'b1;
    end
  end
  initial begin
    bit saw_busy;
    bus.rx = 1'b1;
    bus.parity_en = 1'b0;
    bus.even_parity = 1'b0;
    tick(4);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_data", 32'(bus.data_out), 32'h00);
    chk("reset_valid", 32'(bus.rx_valid), 32'h0);
    chk("reset_busy", 32'(bus.rx_busy), 32'h0);
    chk("reset_perr", 32'(bus.parity_err), 32'h0);
    chk("reset_ferr", 32'(bus.frame_err), 32'h0);
    tick(3);
    send(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(5);
    send(8'h03, 1'b1, 1'b1, 1'b0, 1'b1);
    idle(3);
    send(8'h03, 1'b1, 1'b1, 1'b1, 1'b1);
    idle(3);
    send(8'h07, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(3);
    send(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.rx = 1'b0;
    tick(40);
    chk("low_hold_busy", 32'(bus.rx_busy), 32'h0);
    idle(5);
    bus.rx = 1'b0;
    tick(3);
    saw_busy = 1'b0;
    bus.rx = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      saw_busy |= bus.rx_busy;
    end
    chk("false_start_busy_seen", 32'(saw_busy), 32'h1);
    chk("false_start_busy_clear", 32'(bus.rx_busy), 32'h0);
    chk("false_start_data_held", 32'(bus.data_out), 32'(last_d));
    send(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    send(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
    send(8'h81, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(5);
    send(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, -1, 5);
    @(negedge clk);
    chk("abort_data", 32'(bus.data_out), 32'h00);
    chk("abort_busy", 32'(bus.rx_busy), 32'h0);
    idle(3);
    send(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(4);
`ifdef UART_RX_MAJORITY_EN
    send(8'h96, 1'b0, 1'b0, 1'b0, 1'b1, 3);
    idle(4);
    send(8'h4B, 1'b1, 1'b1, 1'b1, 1'b1, 9);
    idle(4);
`endif
    for (int k = 0; k < 12; k++) begin
      logic [7:0] d;
      logic pen, ev, pb, sb;
      d   = 8'($urandom);
      pen = 1'($urandom);
      ev  = 1'($urandom);
      pb  = 1'($urandom);
      sb  = ($urandom_range(3) != 0);
      send(d, pen, ev, pb, sb);
      idle(sb ? $urandom_range(5) : 2 + $urandom_range(5));
    end
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
    chk("drain_pending", 32'(exp_q.size()), 32'h0);
    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver, the companion of the team's uart_tx; decodes the same frame format the transmitter produces.
- Frame format: 1 start bit (0), 8 data bits LSB first, optional parity bit (even or odd), 1 stop bit (1).
- Sits between the board-level RX pin and the byte-consumer logic.
- Outputs one received byte per frame, marked by a single-cycle valid pulse and per-frame error flags.

Parameters:
- CLKS_PER_BIT, 868: clk cycles per bit period; legal minimum 8; must match the TX baud setting.
- SYNC_STAGES, 2: flops in the rx input synchronizer; legal minimum 2.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- rx  input  1  asynchronous serial line; idles high
- parity_en  input  1  1 = frame carries a parity bit
- even_parity  input  1  1 = even parity; 0 = odd parity
- data_out  output  8  last received byte
- rx_valid  output  1  one-cycle pulse when a frame completes
- rx_busy  output  1  frame reception in progress
- parity_err  output  1  parity mismatch in the last frame
- frame_err  output  1  stop bit sampled low in the last frame

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values:
  - data_out = 0x00, rx_valid = 0, rx_busy = 0, parity_err = 0, frame_err = 0.
  - State = IDLE; all synchronizer flops = 1.
- Synchronizer: rx passes through SYNC_STAGES flops; all decoding uses the synchronized line (rxs).
- States: IDLE, START, DATA, PARITY, STOP.
  - IDLE: a falling edge on rxs (1 in the previous cycle, 0 now) moves to START and sets rx_busy = 1. parity_en and even_parity are latched here; changes mid-frame are ignored. A line held low never retriggers.
  - START: wait CLKS_PER_BIT/2 cycles, then sample. Sample 1 = false start: return to IDLE, rx_busy = 0, no rx_valid. Sample 0 = go to DATA with the bit counter cleared.
  - DATA: sample every CLKS_PER_BIT cycles. Shift in LSB first. After bit 7, go to PARITY if the latched parity_en is 1, otherwise to STOP.
  - PARITY: sample after CLKS_PER_BIT cycles.
    - Even mode: error if XOR(data bits, parity bit) = 1.
    - Odd mode: error if that XOR = 0.
  - STOP: sample after CLKS_PER_BIT cycles, then return to IDLE. No wait for the end of the stop bit.
- Frame completion, on the cycle after the stop sample:
  - rx_valid = 1 for exactly one cycle.
  - data_out, parity_err and frame_err update in that same cycle and hold until the next completion.
  - frame_err = 1 if the stop sample was 0.
  - parity_err = 0 when parity is disabled.
- Errored frames still pulse rx_valid with the byte delivered; the consumer decides whether to discard it.
- After a frame_err, a new start needs rxs to return high first (the falling-edge rule covers this).
- Back-to-back frames: a start edge arriving immediately after the stop sample must be accepted with no lost frame.
- Latency: rx_valid follows the stop-bit midpoint by 1 cycle, plus SYNC_STAGES cycles from the pin.
- Sample counter width: $clog2(CLKS_PER_BIT); it reloads on every state transition.
- rst asserted mid-frame: all state and outputs return to their reset values on the next edge; no rx_valid is issued for the aborted frame.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined: every sample point (start, data, parity, stop) takes rxs at midpoint-1, midpoint and midpoint+1, and uses the 2-of-3 majority as the bit value. rx_valid timing moves 1 cycle later.
- Undefined: a single sample at the midpoint. Area and timing as described above.

Test Plan:
- CLKS_PER_BIT=16, parity off, send 0xA5 with stop=1 -> one rx_valid pulse, data_out=0xA5, parity_err=0, frame_err=0, rx_busy low in the cycle after the pulse.
- Parity on, even, send 0x03 with parity bit 0 -> parity_err=0. Repeat with parity bit 1 -> parity_err=1, data_out=0x03. Odd mode, 0x07 with parity bit 0 -> parity_err=0.
- Send 0x5A with stop bit driven 0, then hold the line low for 40 cycles, then high -> rx_valid once, frame_err=1, data_out=0x5A; no second frame until the line rises and falls again.
- Low glitch of 3 cycles on the idle line -> false start, rx_busy pulses then clears, no rx_valid, data_out unchanged.
- Frames 0x00, 0xFF, 0x81 sent back to back with no idle gap -> three rx_valid pulses in order with the matching bytes, no errors.
- Assert rst during data bit 4 of 0xC3, release, then send 0x3C -> no rx_valid for 0xC3; 0x3C received correctly. With UART_RX_MAJORITY_EN, a 1-cycle inverted glitch at a data-bit midpoint -> byte still received correctly.
